irq_sequencer: RTL and testbench

- Sits between the interrupt controller (port-mapped; reg 0x0 enable, 0x1 write-1-to-clear pending, 0x2 pending readback) and the CPU.
- Runs the CPU interrupt handshake: request, acknowledge, in-service, return, then holdoff.
- Clears the serviced pending bit itself by issuing a port write to controller reg 0x1.
- Shares the controller's port bus between the CPU and its own write, and owns the global interrupt enable (GIE).

---
 rtl/irq_pkg.sv | 29 ++
 rtl/irq_port_mux.sv | 30 +++
 rtl/irq_sequencer.sv | 135 +++++++++++++
 tb/tb_irq_sequencer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared constants, state encoding and helpers for the interrupt sequencer.
// Register map of the interrupt controller as seen on its port bus.
package irq_pkg;

   localparam int IRQ_VEC_W = 4;
   localparam int IC_ADDR_W = 4;
   localparam int IC_DATA_W = 16;

   localparam logic [IC_ADDR_W-1:0] IC_REG_ENABLE  = 4'h0;
   localparam logic [IC_ADDR_W-1:0] IC_REG_CLEAR   = 4'h1;
   localparam logic [IC_ADDR_W-1:0] IC_REG_PENDING = 4'h2;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      CLEAR,
      SERVICE,
      HOLDOFF
   } irq_state_t;

   // Vectors are 1-based, so vector v owns pending bit v-1; a valid vector never
   // exceeds N_IRQ, which keeps the mask inside the low N_IRQ bits.
   function automatic logic [IC_DATA_W-1:0] vec_to_mask(input logic [IRQ_VEC_W-1:0] vec);
      logic [IRQ_VEC_W-1:0] bit_pos;
      bit_pos = vec - IRQ_VEC_W'(1);
      return IC_DATA_W'(1) << bit_pos;
   endfunction

endpackage

// File: rtl/irq_port_mux.sv
// Combinational arbiter for the controller port bus: the CPU passes through
// unless the sequencer needs the bus for its pending-clear write.
module irq_port_mux
   import irq_pkg::*;
(
   input  logic [IC_ADDR_W-1:0] cpu_address,
   input  logic [IC_DATA_W-1:0] cpu_data,
   input  logic                 cpu_wr,
   input  logic                 clear_active,
   input  logic [IC_DATA_W-1:0] clear_data,
   output logic [IC_ADDR_W-1:0] ic_address,
   output logic [IC_DATA_W-1:0] ic_data,
   output logic                 ic_wr,
   output logic                 stall
);

   // A CPU write always wins; the sequencer only takes a cycle the CPU leaves idle.
   always_comb begin
      stall      = clear_active && !cpu_wr;
      ic_address = cpu_address;
      ic_data    = cpu_data;
      ic_wr      = cpu_wr;
      if (stall) begin
         ic_address = IC_REG_CLEAR;
         ic_data    = clear_data;
         ic_wr      = 1'b1;
      end
   end

endmodule

// File: rtl/irq_sequencer.sv
// CPU interrupt handshake sequencer: request, acknowledge, pending clear,
// in-service, return and holdoff, plus ownership of the global interrupt enable.
module irq_sequencer
   import irq_pkg::*;
#(
   parameter int N_IRQ          = 5,
   parameter int HOLDOFF_CYCLES = 2,
   parameter int ACK_TIMEOUT    = 255
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 INT_IN,
   input  logic [IRQ_VEC_W-1:0] IRQ_IN,
   output logic                 CPU_IRQ_REQ,
   output logic [IRQ_VEC_W-1:0] CPU_IRQ_NUM,
   input  logic                 CPU_IRQ_ACK,
   input  logic                 CPU_IRET,
   input  logic                 CPU_GIE_SET,
   input  logic                 CPU_GIE_CLR,
   output logic                 GIE,
   input  logic [IC_ADDR_W-1:0] CPU_ADDRESS,
   input  logic [IC_DATA_W-1:0] CPU_DATA,
   input  logic                 CPU_WR,
   output logic                 CPU_PORT_STALL,
   output logic [IC_ADDR_W-1:0] IC_ADDRESS,
   output logic [IC_DATA_W-1:0] IC_DATA,
   output logic                 IC_WR
);

   localparam int TO_W = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
   localparam int HO_W = (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;

   localparam logic [TO_W-1:0] TO_LAST = TO_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);
   localparam logic [TO_W-1:0] TO_MAX  = '1;
   localparam logic [HO_W-1:0] HO_LAST = HO_W'((HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0);
   localparam logic [IRQ_VEC_W-1:0] MAX_VEC = IRQ_VEC_W'(N_IRQ);

   irq_state_t           state, state_next;
   logic                 gie, gie_next;
   logic [IRQ_VEC_W-1:0] irq_num, irq_num_next;
   logic [TO_W-1:0]      to_cnt, to_cnt_next;
   logic [HO_W-1:0]      ho_cnt, ho_cnt_next;
   logic                 vec_ok;
   logic                 timeout_hit;

   assign vec_ok      = (IRQ_IN != '0) && (IRQ_IN <= MAX_VEC);
   assign timeout_hit = (ACK_TIMEOUT != 0) && (to_cnt == TO_LAST);

   always_ff @(posedge CLK) begin
      if (RST) begin
         state   <= IDLE;
         gie     <= 1'b0;
         irq_num <= '0;
         to_cnt  <= '0;
         ho_cnt  <= '0;
      end else begin
         state   <= state_next;
         gie     <= gie_next;
         irq_num <= irq_num_next;
         to_cnt  <= to_cnt_next;
         ho_cnt  <= ho_cnt_next;
      end
   end

   // The GIE value the CPU is asking for feeds the REQ decision, so that a
   // clear in the same cycle withdraws the request unless an ACK beats it.
   always_comb begin
      state_next   = state;
      irq_num_next = irq_num;
      to_cnt_next  = to_cnt;
      ho_cnt_next  = ho_cnt;
      gie_next     = gie;
      if (CPU_GIE_CLR) begin
         gie_next = 1'b0;
      end else if (CPU_GIE_SET) begin
         gie_next = 1'b1;
      end

      case (state)
         IDLE: begin
            to_cnt_next = '0;
            if (gie && INT_IN && vec_ok) begin
               irq_num_next = IRQ_IN;
               state_next   = REQ;
            end
         end
         REQ: begin
            if (CPU_IRQ_ACK) begin
               gie_next   = 1'b0;
               state_next = CLEAR;
            end else if (!gie_next || timeout_hit) begin
               state_next = IDLE;
            end else if (to_cnt != TO_MAX) begin
               to_cnt_next = to_cnt + TO_W'(1);
            end
         end
         CLEAR: begin
            if (!CPU_WR) begin
               state_next = SERVICE;
            end
         end
         SERVICE: begin
            if (CPU_IRET) begin
               ho_cnt_next = '0;
               state_next  = (HOLDOFF_CYCLES == 0) ? IDLE : HOLDOFF;
            end
         end
         HOLDOFF: begin
            if (ho_cnt == HO_LAST) begin
               state_next = IDLE;
            end else begin
               ho_cnt_next = ho_cnt + HO_W'(1);
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign CPU_IRQ_REQ = (state == REQ);
   assign CPU_IRQ_NUM = irq_num;
   assign GIE         = gie;

   irq_port_mux u_port_mux (
      .cpu_address  (CPU_ADDRESS),
      .cpu_data     (CPU_DATA),
      .cpu_wr       (CPU_WR),
      .clear_active (state == CLEAR),
      .clear_data   (vec_to_mask(irq_num)),
      .ic_address   (IC_ADDRESS),
      .ic_data      (IC_DATA),
      .ic_wr        (IC_WR),
      .stall        (CPU_PORT_STALL)
   );

endmodule

// File: tb/tb_irq_sequencer.sv
// Self-checking bench for irq_sequencer: directed handshake scenarios with
// literal expectations, then randomized traffic against a cycle-indexed model.
module tb_irq_sequencer;

   localparam int N  = 5;
   localparam int HO = 2;
   localparam int TO = 8;

   logic        CLK = 1'b0;
   logic        RST, INT_IN, CPU_IRQ_ACK, CPU_IRET, CPU_GIE_SET, CPU_GIE_CLR, CPU_WR;
   logic [3:0]  IRQ_IN, CPU_ADDRESS;
   logic [15:0] CPU_DATA;
   logic        CPU_IRQ_REQ, GIE, CPU_PORT_STALL, IC_WR;
   logic [3:0]  CPU_IRQ_NUM, IC_ADDRESS;
   logic [15:0] IC_DATA;

   int checks = 0;
   int errors = 0;

   irq_sequencer #(.N_IRQ(N), .HOLDOFF_CYCLES(HO), .ACK_TIMEOUT(TO)) dut (
      .CLK(CLK), .RST(RST), .INT_IN(INT_IN), .IRQ_IN(IRQ_IN),
      .CPU_IRQ_REQ(CPU_IRQ_REQ), .CPU_IRQ_NUM(CPU_IRQ_NUM), .CPU_IRQ_ACK(CPU_IRQ_ACK),
      .CPU_IRET(CPU_IRET), .CPU_GIE_SET(CPU_GIE_SET), .CPU_GIE_CLR(CPU_GIE_CLR), .GIE(GIE),
      .CPU_ADDRESS(CPU_ADDRESS), .CPU_DATA(CPU_DATA), .CPU_WR(CPU_WR),
      .CPU_PORT_STALL(CPU_PORT_STALL), .IC_ADDRESS(IC_ADDRESS), .IC_DATA(IC_DATA), .IC_WR(IC_WR)
   );

   always #5 CLK = ~CLK;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic applyStimulus();
      RST         = ($urandom_range(0, 99) < 2);
      INT_IN      = ($urandom_range(0, 99) < 60);
      IRQ_IN      = 4'($urandom_range(0, 7));
      CPU_IRQ_ACK = ($urandom_range(0, 99) < 20);
      CPU_IRET    = ($urandom_range(0, 99) < 15);
      CPU_GIE_SET = ($urandom_range(0, 99) < 25);
      CPU_GIE_CLR = ($urandom_range(0, 99) < 6);
      CPU_WR      = ($urandom_range(0, 99) < 35);
      CPU_ADDRESS = 4'($urandom_range(0, 15));
      CPU_DATA    = 16'($urandom_range(0, 65535));
   endtask

   // Reference model: cycle-indexed bookkeeping of the handshake phases.
   // A request started in cycle s may live through cycle s+TO-1; an IRET in
   // cycle c makes cycle c+1+HO the first one that can accept a new interrupt.
   int         cyc = 0;
   bit         m_valid = 1'b0;
   bit         m_gie, m_req, m_clr, m_svc;
   logic [3:0] m_num;
   int         m_req_start, m_idle_at;

   always @(posedge CLK) begin : model
      bit g;
      if (RST) begin
         m_valid   = 1'b1;
         m_gie     = 1'b0;
         m_req     = 1'b0;
         m_clr     = 1'b0;
         m_svc     = 1'b0;
         m_num     = 4'd0;
         m_idle_at = cyc + 1;
      end else if (m_valid) begin
         g = CPU_GIE_CLR ? 1'b0 : (CPU_GIE_SET ? 1'b1 : m_gie);
         if (m_req) begin
            if (CPU_IRQ_ACK) begin
               m_req = 1'b0;
               m_clr = 1'b1;
               g     = 1'b0;
            end else if (!g || (cyc - m_req_start == TO - 1)) begin
               m_req = 1'b0;
            end
         end else if (m_clr) begin
            if (!CPU_WR) begin
               m_clr = 1'b0;
               m_svc = 1'b1;
            end
         end else if (m_svc) begin
            if (CPU_IRET) begin
               m_svc     = 1'b0;
               m_idle_at = cyc + 1 + HO;
            end
         end else if (cyc >= m_idle_at) begin
            if (m_gie && INT_IN && IRQ_IN >= 1 && int'(IRQ_IN) <= N) begin
               m_req       = 1'b1;
               m_num       = IRQ_IN;
               m_req_start = cyc + 1;
            end
         end
         m_gie = g;
      end
      cyc++;
   end

   always @(negedge CLK) begin : compare
      bit          exp_stall;
      logic [3:0]  exp_addr;
      logic [15:0] exp_data;
      if (m_valid) begin
         exp_stall = m_clr && !CPU_WR;
         exp_addr  = exp_stall ? 4'h1 : CPU_ADDRESS;
         exp_data  = exp_stall ? (16'h1 << (m_num - 4'd1)) : CPU_DATA;
         checkOutput("model_req", 32'(CPU_IRQ_REQ), 32'(m_req));
         checkOutput("model_num", 32'(CPU_IRQ_NUM), 32'(m_num));
         checkOutput("model_gie", 32'(GIE), 32'(m_gie));
         checkOutput("model_stall", 32'(CPU_PORT_STALL), 32'(exp_stall));
         checkOutput("model_ic_addr", 32'(IC_ADDRESS), 32'(exp_addr));
         checkOutput("model_ic_data", 32'(IC_DATA), 32'(exp_data));
         checkOutput("model_ic_wr", 32'(IC_WR), 32'(exp_stall || CPU_WR));
      end
   end

   initial begin
      RST = 1'b1; INT_IN = 1'b0; IRQ_IN = 4'd0; CPU_IRQ_ACK = 1'b0; CPU_IRET = 1'b0;
      CPU_GIE_SET = 1'b0; CPU_GIE_CLR = 1'b0; CPU_WR = 1'b0;
      CPU_ADDRESS = 4'h2; CPU_DATA = 16'h1234;
      step(); step();
      checkOutput("reset_gie", 32'(GIE), 32'd0);
      checkOutput("reset_req", 32'(CPU_IRQ_REQ), 32'd0);
      checkOutput("reset_num", 32'(CPU_IRQ_NUM), 32'd0);
      checkOutput("reset_stall", 32'(CPU_PORT_STALL), 32'd0);
      checkOutput("reset_ic_addr", 32'(IC_ADDRESS), 32'h2);
      checkOutput("reset_ic_data", 32'(IC_DATA), 32'h1234);
      RST = 1'b0; CPU_ADDRESS = 4'h0; CPU_DATA = 16'h0;

      CPU_GIE_SET = 1'b1; step(); CPU_GIE_SET = 1'b0;
      checkOutput("gie_set", 32'(GIE), 32'd1);
      INT_IN = 1'b1; IRQ_IN = 4'd3; step();
      checkOutput("req_up", 32'(CPU_IRQ_REQ), 32'd1);
      checkOutput("req_num3", 32'(CPU_IRQ_NUM), 32'd3);
      IRQ_IN = 4'd1; step();
      checkOutput("num_held", 32'(CPU_IRQ_NUM), 32'd3);
      CPU_IRQ_ACK = 1'b1; step(); CPU_IRQ_ACK = 1'b0; INT_IN = 1'b0; #1;
      checkOutput("clr_addr", 32'(IC_ADDRESS), 32'h1);
      checkOutput("clr_data", 32'(IC_DATA), 32'h0004);
      checkOutput("clr_wr", 32'(IC_WR), 32'd1);
      checkOutput("clr_stall", 32'(CPU_PORT_STALL), 32'd1);
      checkOutput("ack_gie", 32'(GIE), 32'd0);
      step();
      checkOutput("svc_stall", 32'(CPU_PORT_STALL), 32'd0);

      CPU_IRET = 1'b1; step(); CPU_IRET = 1'b0;
      CPU_GIE_SET = 1'b1; INT_IN = 1'b1; IRQ_IN = 4'd2; step(); CPU_GIE_SET = 1'b0;
      checkOutput("holdoff_a", 32'(CPU_IRQ_REQ), 32'd0);
      step();
      checkOutput("holdoff_b", 32'(CPU_IRQ_REQ), 32'd0);
      step();
      checkOutput("req_after_holdoff", 32'(CPU_IRQ_REQ), 32'd1);
      checkOutput("req_num2", 32'(CPU_IRQ_NUM), 32'd2);

      INT_IN = 1'b0; CPU_WR = 1'b1; CPU_ADDRESS = 4'h0; CPU_DATA = 16'h001F;
      CPU_IRQ_ACK = 1'b1; step(); CPU_IRQ_ACK = 1'b0;
      for (int i = 0; i < 2; i++) begin
         checkOutput("coll_wr", 32'(IC_WR), 32'd1);
         checkOutput("coll_addr", 32'(IC_ADDRESS), 32'h0);
         checkOutput("coll_data", 32'(IC_DATA), 32'h001F);
         checkOutput("coll_stall", 32'(CPU_PORT_STALL), 32'd0);
         if (i == 0) step();
      end
      CPU_WR = 1'b0; #1;
      checkOutput("late_clr_addr", 32'(IC_ADDRESS), 32'h1);
      checkOutput("late_clr_data", 32'(IC_DATA), 32'h0002);
      checkOutput("late_clr_stall", 32'(CPU_PORT_STALL), 32'd1);
      step();

      RST = 1'b1; step(); RST = 1'b0;
      checkOutput("rst_svc_req", 32'(CPU_IRQ_REQ), 32'd0);
      checkOutput("rst_svc_stall", 32'(CPU_PORT_STALL), 32'd0);
      CPU_GIE_SET = 1'b1; step(); CPU_GIE_SET = 1'b0;
      INT_IN = 1'b1; IRQ_IN = 4'd4; step(); INT_IN = 1'b0;
      checkOutput("post_rst_req", 32'(CPU_IRQ_REQ), 32'd1);
      checkOutput("post_rst_num", 32'(CPU_IRQ_NUM), 32'd4);
      for (int i = 1; i < TO; i++) begin
         step();
         checkOutput("timeout_hold", 32'(CPU_IRQ_REQ), 32'd1);
      end
      step();
      checkOutput("timeout_drop", 32'(CPU_IRQ_REQ), 32'd0);
      checkOutput("timeout_no_wr", 32'(IC_WR), 32'd0);

      CPU_GIE_SET = 1'b1; CPU_GIE_CLR = 1'b1; step(); CPU_GIE_SET = 1'b0; CPU_GIE_CLR = 1'b0;
      checkOutput("set_clr_gie", 32'(GIE), 32'd0);
      CPU_GIE_SET = 1'b1; step(); CPU_GIE_SET = 1'b0;
      INT_IN = 1'b1; IRQ_IN = 4'd6; step();
      checkOutput("vec6_ignored", 32'(CPU_IRQ_REQ), 32'd0);
      IRQ_IN = 4'd0; step();
      checkOutput("vec0_ignored", 32'(CPU_IRQ_REQ), 32'd0);
      IRQ_IN = 4'd5; step(); INT_IN = 1'b0;
      checkOutput("vec5_req", 32'(CPU_IRQ_REQ), 32'd1);
      CPU_GIE_CLR = 1'b1; step(); CPU_GIE_CLR = 1'b0;
      checkOutput("gie_clr_drops_req", 32'(CPU_IRQ_REQ), 32'd0);

      repeat (3000) begin
         applyStimulus();
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
